// File: rtl/bbox_update_ctrl_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | bbox_update_ctrl_pkg : shared constants, box field layout and FSM states  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package bbox_update_ctrl_pkg;

  localparam logic [63:0] BBOX_INVALID = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int          COORD_W      = 16;

  localparam int X0_LSB = 48;
  localparam int Y0_LSB = 32;
  localparam int X1_LSB = 16;
  localparam int Y1_LSB = 0;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_READY   = 2'd1,
    ST_LOAD    = 2'd2
  } state_t;

  function automatic logic [COORD_W-1:0] box_coord(input logic [63:0] box, input int lsb);
    return box[lsb +: COORD_W];
  endfunction

  function automatic logic [63:0] box_pack(input logic [COORD_W-1:0] x0,
                                           input logic [COORD_W-1:0] y0,
                                           input logic [COORD_W-1:0] x1,
                                           input logic [COORD_W-1:0] y1);
    return {x0, y0, x1, y1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bbox_update_ctrl_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | bbox_update_ctrl_if : detection input, overlay write port and status      |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
interface bbox_update_ctrl_if;

  logic [63:0] det_bbox_data;
  logic        det_bbox_valid;
  logic        det_bbox_ready;
  logic        det_list_done;
  logic        frame_end;
  logic [63:0] bbox_data_out;
  logic        bbox_data_out_valid;
  logic        busy;
  logic [7:0]  drop_cnt;

  modport master (
    output det_bbox_data, det_bbox_valid, det_list_done, frame_end,
    input  det_bbox_ready, bbox_data_out, bbox_data_out_valid, busy, drop_cnt
  );

  modport slave (
    input  det_bbox_data, det_bbox_valid, det_list_done, frame_end,
    output det_bbox_ready, bbox_data_out, bbox_data_out_valid, busy, drop_cnt
  );

endinterface
`default_nettype wire

// File: rtl/bbox_update_ctrl_clamp_check.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | bbox_clamp_check : clamps a box to the frame and flags inverted boxes     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module bbox_clamp_check
  import bbox_update_ctrl_pkg::*;
#(
  parameter int FRAME_WIDTH  = 16,
  parameter int FRAME_HEIGHT = 9
) (
  input  logic [63:0] box_i,
  output logic [63:0] box_o,
  output logic        malformed_o
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(FRAME_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(FRAME_HEIGHT - 1);

  logic [COORD_W-1:0] raw_x0, raw_y0, raw_x1, raw_y1;
  logic [COORD_W-1:0] cl_x0, cl_y0, cl_x1, cl_y1;

  assign raw_x0 = box_coord(box_i, X0_LSB);
  assign raw_y0 = box_coord(box_i, Y0_LSB);
  assign raw_x1 = box_coord(box_i, X1_LSB);
  assign raw_y1 = box_coord(box_i, Y1_LSB);

  assign cl_x0 = (raw_x0 > X_MAX) ? X_MAX : raw_x0;
  assign cl_y0 = (raw_y0 > Y_MAX) ? Y_MAX : raw_y0;
  assign cl_x1 = (raw_x1 > X_MAX) ? X_MAX : raw_x1;
  assign cl_y1 = (raw_y1 > Y_MAX) ? Y_MAX : raw_y1;

  // Inversion is judged after clamping, so a box lying fully off-frame collapses and passes.
  assign malformed_o = (cl_x0 > cl_x1) || (cl_y0 > cl_y1);
  assign box_o       = box_pack(cl_x0, cl_y0, cl_x1, cl_y1);

endmodule
`default_nettype wire

// File: rtl/bbox_update_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | bbox_update_ctrl : collects a detection list, then writes a full slot set |
// | to the overlay stage at the next vertical blank. Rev 1.0                  |
// +---------------------------------------------------------------------------+
module bbox_update_ctrl
  import bbox_update_ctrl_pkg::*;
#(
  parameter int FRAME_WIDTH  = 16,
  parameter int FRAME_HEIGHT = 9,
  parameter int MAX_BBOX     = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  bbox_update_ctrl_if.slave  bus
);

  localparam int              CNT_W    = $clog2(MAX_BBOX + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_BBOX);

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] slot_q;
  logic [63:0]      store_q [MAX_BBOX];
  logic [63:0]      out_data_q;
  logic             out_valid_q;
  logic [7:0]       drop_q;

  logic [63:0]      box_clamped;
  logic             box_malformed;
  logic [63:0]      slot_data;

  bbox_clamp_check #(
    .FRAME_WIDTH  (FRAME_WIDTH),
    .FRAME_HEIGHT (FRAME_HEIGHT)
  ) u_clamp (
    .box_i       (bus.det_bbox_data),
    .box_o       (box_clamped),
    .malformed_o (box_malformed)
  );

  assign bus.det_bbox_ready      = (state_q == ST_COLLECT);
  assign bus.busy                = (state_q != ST_COLLECT);
  assign bus.bbox_data_out       = out_data_q;
  assign bus.bbox_data_out_valid = out_valid_q;
  assign bus.drop_cnt            = drop_q;

  // Slots beyond the stored count read as "no box" so stale entries never reappear.
  always_comb begin
    slot_data = BBOX_INVALID;
    for (int k = 0; k < MAX_BBOX; k++) begin
      if ((slot_q == CNT_W'(k)) && (CNT_W'(k) < count_q)) begin
        slot_data = store_q[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      count_q     <= '0;
      slot_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= '0;
      for (int k = 0; k < MAX_BBOX; k++) begin
        store_q[k] <= '0;
      end
    end else begin
      case (state_q)
        ST_COLLECT: begin
          out_valid_q <= 1'b0;
          if (bus.det_bbox_valid) begin
            if (box_malformed || (count_q == CNT_FULL)) begin
              if (drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
              end
            end else begin
              for (int k = 0; k < MAX_BBOX; k++) begin
                if (count_q == CNT_W'(k)) begin
                  store_q[k] <= box_clamped;
                end
              end
              count_q <= count_q + 1'b1;
            end
          end
          // A beat in the commit cycle has already been handled above.
          if (bus.det_list_done) begin
            state_q <= ST_READY;
          end
        end

        ST_READY: begin
          if (bus.frame_end) begin
            state_q     <= ST_LOAD;
            out_valid_q <= 1'b1;
            out_data_q  <= slot_data;
            slot_q      <= slot_q + 1'b1;
          end
        end

        ST_LOAD: begin
          if (slot_q == CNT_FULL) begin
            state_q     <= ST_COLLECT;
            out_valid_q <= 1'b0;
            count_q     <= '0;
            slot_q      <= '0;
          end else begin
            out_data_q  <= slot_data;
            slot_q      <= slot_q + 1'b1;
          end
        end

        default: begin
          state_q     <= ST_COLLECT;
          out_valid_q <= 1'b0;
          count_q     <= '0;
          slot_q      <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bbox_update_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_bbox_update_ctrl : directed and randomized bench with reference model  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_bbox_update_ctrl;

  localparam int FW   = 16;
  localparam int FH   = 9;
  localparam int NBOX = 5;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk;
  logic rst_n;
  bbox_update_ctrl_if bus ();

  bbox_update_ctrl #(
    .FRAME_WIDTH  (FW),
    .FRAME_HEIGHT (FH),
    .MAX_BBOX     (NBOX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_list [$];
  logic [63:0] m_pend [$];
  bit          m_commit;
  bit          m_valid;
  logic [63:0] m_data;
  int          m_drop;
  logic [63:0] t_box;

  function automatic logic [63:0] clamp_box(input logic [63:0] b);
    logic [15:0] x0, y0, x1, y1;
    x0 = b[63:48]; y0 = b[47:32]; x1 = b[31:16]; y1 = b[15:0];
    if (x0 > 16'(FW - 1)) x0 = 16'(FW - 1);
    if (x1 > 16'(FW - 1)) x1 = 16'(FW - 1);
    if (y0 > 16'(FH - 1)) y0 = 16'(FH - 1);
    if (y1 > 16'(FH - 1)) y1 = 16'(FH - 1);
    return {x0, y0, x1, y1};
  endfunction

  function automatic bit is_bad(input logic [63:0] c);
    return (c[63:48] > c[31:16]) || (c[47:32] > c[15:0]);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_list.delete(); m_pend.delete();
        m_commit = 0; m_valid = 0; m_data = '0; m_drop = 0;
      end else if (m_valid) begin
        if (m_pend.size() > 0) m_data = m_pend.pop_front();
        else m_valid = 0;
      end else if (m_commit) begin
        if (bus.frame_end) begin
          for (int k = 0; k < NBOX; k++)
            m_pend.push_back(k < m_list.size() ? m_list[k] : ONES);
          m_list.delete();
          m_commit = 0;
          m_valid  = 1;
          m_data   = m_pend.pop_front();
        end
      end else begin
        if (bus.det_bbox_valid) begin
          t_box = clamp_box(bus.det_bbox_data);
          if (is_bad(t_box) || m_list.size() >= NBOX) begin
            if (m_drop < 255) m_drop++;
          end else begin
            m_list.push_back(t_box);
          end
        end
        if (bus.det_list_done) m_commit = 1;
      end
    end
  end

  // ---------------- compare / monitor ----------------
  logic [63:0] cap [$];
  int run_len = 0;
  int bursts  = 0;
  int last_burst = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run_len = 0;
      end else begin
        chk("ready", 64'(bus.det_bbox_ready), 64'(!m_commit && !m_valid));
        chk("busy", 64'(bus.busy), 64'(m_commit || m_valid));
        chk("out_valid", 64'(bus.bbox_data_out_valid), 64'(m_valid));
        chk("out_data", bus.bbox_data_out, m_data);
        chk("drop_cnt", 64'(bus.drop_cnt), 64'(m_drop));
        if (bus.bbox_data_out_valid) begin
          cap.push_back(bus.bbox_data_out);
          run_len++;
        end else if (run_len > 0) begin
          last_burst = run_len;
          run_len = 0;
          bursts++;
        end
      end
    end
  end

  // ---------------- stimulus helpers (all start/end at posedge+2) ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send_box(input logic [63:0] b, input bit with_done);
    bus.det_bbox_valid = 1'b1;
    bus.det_bbox_data  = b;
    bus.det_list_done  = with_done;
    @(posedge clk); #2;
    bus.det_bbox_valid = 1'b0;
    bus.det_list_done  = 1'b0;
  endtask

  task automatic pulse_done();
    bus.det_list_done = 1'b1;
    @(posedge clk); #2;
    bus.det_list_done = 1'b0;
  endtask

  task automatic pulse_fe();
    bus.frame_end = 1'b1;
    @(posedge clk); #2;
    bus.frame_end = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    cap.delete();
  endtask

  task automatic wait_bursts(input int target);
    int n = 0;
    while (bursts < target && n < 60) begin
      @(posedge clk); n++;
    end
    #2;
    if (bursts < target) begin
      total++; bad++;
      $display("FAIL burst_timeout: got %0d bursts expected %0d", bursts, target);
    end
  endtask

  function automatic logic [63:0] rand_box();
    logic [15:0] x0, y0, x1, y1;
    x0 = 16'($urandom_range(0, 18));
    y0 = 16'($urandom_range(0, 11));
    if ($urandom_range(0, 3) == 0) begin
      x1 = 16'($urandom_range(0, 22));
      y1 = 16'($urandom_range(0, 14));
    end else begin
      x1 = x0 + 16'($urandom_range(0, 6));
      y1 = y0 + 16'($urandom_range(0, 5));
    end
    if ($urandom_range(0, 15) == 0) x1 = 16'hFFF0;
    return {x0, y0, x1, y1};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int b0;
    int nb;
    bit coinc;
    rst_n = 1'b0;
    bus.det_bbox_data  = '0;
    bus.det_bbox_valid = 1'b0;
    bus.det_list_done  = 1'b0;
    bus.frame_end      = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_data", bus.bbox_data_out, 64'h0);
    chk("reset_valid", 64'(bus.bbox_data_out_valid), 64'h0);
    chk("reset_drop", 64'(bus.drop_cnt), 64'h0);
    chk("reset_busy", 64'(bus.busy), 64'h0);
    chk("reset_ready", 64'(bus.det_bbox_ready), 64'h1);
    @(posedge clk); #2;

    // model pinning
    chk("model_clamp", clamp_box(64'h0002_0001_0014_000C), 64'h0002_0001_000F_0008);
    chk("model_bad", 64'(is_bad(clamp_box(64'h000A_0003_0004_0006))), 64'h1);

    // two boxes, then padding
    do_reset();
    send_box(64'h0001_0001_0005_0004, 0);
    send_box(64'h0008_0002_000C_0006, 0);
    pulse_done();
    idle(1);
    b0 = bursts;
    pulse_fe();
    wait_bursts(b0 + 1);
    chk("t1_len", 64'(cap.size()), 64'd5);
    chk("t1_w0", cap[0], 64'h0001_0001_0005_0004);
    chk("t1_w1", cap[1], 64'h0008_0002_000C_0006);
    chk("t1_w2", cap[2], ONES);
    chk("t1_w4", cap[4], ONES);
    chk("t1_drop", 64'(bus.drop_cnt), 64'd0);
    chk("t1_busy", 64'(bus.busy), 64'd0);

    // seven boxes: two overflow drops
    do_reset();
    for (int i = 0; i < 7; i++) send_box({16'(i), 16'd1, 16'(i + 1), 16'd2}, 0);
    pulse_done();
    @(negedge clk);
    chk("t2_ready_after_done", 64'(bus.det_bbox_ready), 64'd0);
    @(posedge clk); #2;
    b0 = bursts;
    pulse_fe();
    wait_bursts(b0 + 1);
    chk("t2_len", 64'(cap.size()), 64'd5);
    chk("t2_w0", cap[0], 64'h0000_0001_0001_0002);
    chk("t2_w4", cap[4], 64'h0004_0001_0005_0002);
    chk("t2_drop", 64'(bus.drop_cnt), 64'd2);

    // clamp and malformed
    do_reset();
    send_box(64'h0002_0001_0014_000C, 0);
    send_box(64'h000A_0003_0004_0006, 0);
    pulse_done();
    b0 = bursts;
    pulse_fe();
    wait_bursts(b0 + 1);
    chk("t3_w0", cap[0], 64'h0002_0001_000F_0008);
    chk("t3_w1", cap[1], ONES);
    chk("t3_drop", 64'(bus.drop_cnt), 64'd1);

    // frame_end in COLLECT ignored, then empty list
    do_reset();
    b0 = bursts;
    pulse_fe();
    idle(1);
    pulse_fe();
    idle(3);
    chk("t4_no_burst", 64'(bursts - b0), 64'd0);
    chk("t4_no_cap", 64'(cap.size()), 64'd0);
    pulse_done();
    pulse_fe();
    wait_bursts(b0 + 1);
    chk("t4_len", 64'(cap.size()), 64'd5);
    chk("t4_w0", cap[0], ONES);
    chk("t4_w4", cap[4], ONES);

    // beat coincident with done, second frame_end during LOAD
    do_reset();
    send_box(64'h0003_0003_0004_0004, 0);
    send_box(64'h0005_0000_0009_0008, 1);
    b0 = bursts;
    pulse_fe();
    pulse_fe();
    wait_bursts(b0 + 1);
    chk("t5_burst_len", 64'(last_burst), 64'd5);
    chk("t5_w1", cap[1], 64'h0005_0000_0009_0008);
    chk("t5_w2", cap[2], ONES);
    idle(4);
    chk("t5_no_second", 64'(bursts - b0), 64'd1);

    // reset in the 3rd LOAD cycle
    do_reset();
    send_box(64'h000A_0003_0004_0006, 0);
    send_box(64'h0001_0001_0002_0002, 1);
    pulse_fe();
    idle(2);
    chk("t6_pre_valid", 64'(bus.bbox_data_out_valid), 64'd1);
    chk("t6_pre_drop", 64'(bus.drop_cnt), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(bus.bbox_data_out_valid), 64'd0);
    chk("t6_rst_drop", 64'(bus.drop_cnt), 64'd0);
    chk("t6_rst_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_ready", 64'(bus.det_bbox_ready), 64'd1);
    @(posedge clk); #2;

    // randomized lists
    for (int l = 0; l < 120; l++) begin
      nb = $urandom_range(0, 8);
      coinc = 1'($urandom_range(0, 1));
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 1) pulse_fe();
          else idle(1);
        end
        send_box(rand_box(), coinc && (i == nb - 1));
      end
      if (!(coinc && nb > 0)) pulse_done();
      repeat ($urandom_range(0, 3)) begin
        bus.det_bbox_valid = 1'($urandom_range(0, 1));
        bus.det_bbox_data  = rand_box();
        bus.det_list_done  = 1'($urandom_range(0, 1));
        @(posedge clk); #2;
        bus.det_bbox_valid = 1'b0;
        bus.det_list_done  = 1'b0;
      end
      b0 = bursts;
      pulse_fe();
      if ($urandom_range(0, 1) == 1) pulse_fe();
      wait_bursts(b0 + 1);
      chk("rand_burst_len", 64'(last_burst), 64'd5);
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
